// File: rtl/dom_sched_pkg.sv
// Shared definitions for the DOM GF(2^2) multiplier scheduler.
//   share_w : bits per shared GF(2^2) element (2 bits per share)
//   idw     : requester-ID width for a given requester count
//   tag_t   : in-flight tag (valid + requester ID), sized for up to 8 requesters
package dom_sched_pkg;

    localparam int MAX_IDW = 3;

    function automatic int share_w(input int shares);
        return 2 * shares;
    endfunction

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic               vld;
        logic [MAX_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/dom_rr_arbiter.sv
// Round-robin arbiter. Search starts at the pointer; the pointer moves to
// grant+1 only when the caller reports that the grant was taken (advance).
//   ClkxCI, RstxBI : clock, async active-low reset
//   req            : request vector
//   advance        : grant accepted this cycle
//   gnt, gnt_id    : one-hot grant and its index (valid when any=1)
//   any            : at least one request present
module dom_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            ClkxCI,
    input  logic            RstxBI,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW-1:0] ptr;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v % NREQ);
    endfunction

    always_comb begin
        any    = 1'b0;
        gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[wrap(int'(ptr) + i)]) begin
                any    = 1'b1;
                gnt_id = wrap(int'(ptr) + i);
            end
        end
        gnt = any ? (NREQ'(1) << gnt_id) : '0;
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI)      ptr <= '0;
        else if (advance) ptr <= wrap(int'(gnt_id) + 1);
    end

endmodule

// File: rtl/dom_mul_gf2_scheduler.sv
// Time-multiplexes one pipelined DOM GF(2^2) multiplier between NREQ masked
// requesters, pairing each issue with one fresh randomness word and returning
// products in issue order through a credit-protected response FIFO.
//   ClkxCI, RstxBI          : clock, async active-low reset
//   ReqValidxSI/ReqReadyxSO : per-requester handshake (ready is the one-hot grant)
//   ReqXxDI, ReqYxDI        : shared operands, requester r at slice r
//   RndValidxSI/RndReadyxSO : randomness handshake; RndZxDI, RndBxDI fresh words
//   Mul{X,Y,Z,B}xDO         : multiplier inputs from the issue register
//   MulQxDI                 : multiplier result, LATENCY cycles after its inputs
//   RspValidxSO/RspReadyxSI : response handshake; RspIdxDO, RspQxDO payload
// Optional: define DOM_SCHED_IDLE_ZERO_EN to load zeros into the issue
// register on idle cycles instead of holding the last issued values.
module dom_mul_gf2_scheduler
    import dom_sched_pkg::*;
#(
    parameter int SHARES    = 2,
    parameter int NREQ      = 4,
    parameter int LATENCY   = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic                               ClkxCI,
    input  logic                               RstxBI,
    input  logic [NREQ-1:0]                    ReqValidxSI,
    output logic [NREQ-1:0]                    ReqReadyxSO,
    input  logic [NREQ*share_w(SHARES)-1:0]    ReqXxDI,
    input  logic [NREQ*share_w(SHARES)-1:0]    ReqYxDI,
    input  logic                               RndValidxSI,
    output logic                               RndReadyxSO,
    input  logic [SHARES*(SHARES-1)-1:0]       RndZxDI,
    input  logic [share_w(SHARES)-1:0]         RndBxDI,
    output logic [share_w(SHARES)-1:0]         MulXxDO,
    output logic [share_w(SHARES)-1:0]         MulYxDO,
    output logic [SHARES*(SHARES-1)-1:0]       MulZxDO,
    output logic [share_w(SHARES)-1:0]         MulBxDO,
    input  logic [share_w(SHARES)-1:0]         MulQxDI,
    output logic                               RspValidxSO,
    input  logic                               RspReadyxSI,
    output logic [idw(NREQ)-1:0]               RspIdxDO,
    output logic [share_w(SHARES)-1:0]         RspQxDO
);

    localparam int SW  = share_w(SHARES);
    localparam int ZW  = SHARES * (SHARES - 1);
    localparam int IDW = idw(NREQ);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int PW  = idw(RSP_DEPTH);

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            any_req;
    logic [CW-1:0]   credits;
    logic            issue;

    // Credits count free FIFO slots not yet claimed by in-flight operations,
    // so every multiplier result has a guaranteed place to land.
    assign issue = RstxBI & any_req & RndValidxSI & (credits != '0);

    dom_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .ClkxCI  (ClkxCI),
        .RstxBI  (RstxBI),
        .req     (ReqValidxSI),
        .advance (issue),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any     (any_req)
    );

    assign ReqReadyxSO = issue ? gnt : '0;
    assign RndReadyxSO = issue;

    // Issue register: operands and randomness enter the multiplier together.
    logic [SW-1:0] x_q, y_q, b_q;
    logic [ZW-1:0] z_q;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            b_q <= '0;
        end else if (issue) begin
            x_q <= ReqXxDI[gnt_id*SW +: SW];
            y_q <= ReqYxDI[gnt_id*SW +: SW];
            z_q <= RndZxDI;
            b_q <= RndBxDI;
        end
`ifdef DOM_SCHED_IDLE_ZERO_EN
        else begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            b_q <= '0;
        end
`endif
    end

    assign MulXxDO = x_q;
    assign MulYxDO = y_q;
    assign MulZxDO = z_q;
    assign MulBxDO = b_q;

    // Tag pipe: stage k is valid k+1 cycles after issue; the head lines up
    // with the multiplier result.
    tag_t tag_pipe [LATENCY:0];

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            for (int i = 0; i <= LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{vld: issue, id: MAX_IDW'(gnt_id)};
            for (int i = 1; i <= LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    logic unused_tag_bits;
    assign unused_tag_bits = ^tag_pipe[LATENCY].id;

    // Response FIFO
    logic [SW-1:0]  buf_q  [RSP_DEPTH];
    logic [IDW-1:0] buf_id [RSP_DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  cnt;
    logic           wr, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr  = tag_pipe[LATENCY].vld;
    assign pop = (cnt != '0) & RspReadyxSI;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                buf_q[i]  <= '0;
                buf_id[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            credits <= CW'(RSP_DEPTH);
        end else begin
            if (wr) begin
                buf_q[wr_ptr]  <= MulQxDI;
                buf_id[wr_ptr] <= tag_pipe[LATENCY].id[IDW-1:0];
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            cnt     <= cnt + CW'(wr) - CW'(pop);
            credits <= credits - CW'(issue) + CW'(pop);
        end
    end

    assign RspValidxSO = (cnt != '0);
    assign RspIdxDO    = buf_id[rd_ptr];
    assign RspQxDO     = buf_q[rd_ptr];

endmodule

// File: tb/tb_dom_mul_gf2_scheduler.sv
// Self-checking bench for dom_mul_gf2_scheduler (defaults: SHARES=2, NREQ=4,
// LATENCY=1, RSP_DEPTH=2). A behavioural multiplier closes the loop; the
// reference model tracks outstanding operations as a queue and derives
// credits, grants and response timing from it.
module tb_dom_mul_gf2_scheduler;

    localparam int RSP_DEPTH = 2;

    logic        ClkxCI = 1'b0;
    logic        RstxBI = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  ReqReadyxSO;
    logic [15:0] req_x = '0, req_y = '0;
    logic        rnd_valid = 1'b0;
    logic        RndReadyxSO;
    logic [1:0]  rnd_z = '0;
    logic [3:0]  rnd_b = '0;
    logic [3:0]  MulXxDO, MulYxDO, MulBxDO;
    logic [1:0]  MulZxDO;
    logic [3:0]  mul_q;
    logic        RspValidxSO;
    logic        rsp_ready = 1'b0;
    logic [1:0]  RspIdxDO;
    logic [3:0]  RspQxDO;

    always #5 ClkxCI = ~ClkxCI;

    dom_mul_gf2_scheduler #(.SHARES(2), .NREQ(4), .LATENCY(1), .RSP_DEPTH(RSP_DEPTH)) dut (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI),
        .ReqValidxSI(req_valid), .ReqReadyxSO(ReqReadyxSO),
        .ReqXxDI(req_x), .ReqYxDI(req_y),
        .RndValidxSI(rnd_valid), .RndReadyxSO(RndReadyxSO),
        .RndZxDI(rnd_z), .RndBxDI(rnd_b),
        .MulXxDO(MulXxDO), .MulYxDO(MulYxDO), .MulZxDO(MulZxDO), .MulBxDO(MulBxDO),
        .MulQxDI(mul_q),
        .RspValidxSO(RspValidxSO), .RspReadyxSI(rsp_ready),
        .RspIdxDO(RspIdxDO), .RspQxDO(RspQxDO)
    );

    // GF(2^2) with x^2 = x + 1
    function automatic logic [1:0] gfmul(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
                (a[0] & b[0]) ^ (a[1] & b[1])};
    endfunction

    function automatic logic [1:0] unm(input logic [3:0] v);
        return v[1:0] ^ v[3:2];
    endfunction

    // Behavioural 1-cycle masked multiplier: result shares recombine to X*Y.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) mul_q <= '0;
        else begin
            mul_q[1:0] <= gfmul(unm(MulXxDO), unm(MulYxDO)) ^ MulBxDO[1:0] ^ MulZxDO;
            mul_q[3:2] <= MulBxDO[1:0] ^ MulZxDO;
        end
    end

    int asserts = 0;
    int fails   = 0;

    // Reference model state
    int         cyc = 0;
    int         ptr = 0;
    int         pend_id [$];
    logic [1:0] pend_p  [$];
    int         pend_t  [$];
    logic [3:0] exp_mulx = '0, exp_muly = '0, exp_mulb = '0;
    logic [1:0] exp_mulz = '0;
    logic       exp_issue, exp_rspv;
    int         exp_g;
    logic [3:0] exp_gnt;
    logic [1:0] exp_id, exp_prod;

    task automatic model_reset();
        ptr = 0;
        pend_id.delete(); pend_p.delete(); pend_t.delete();
        exp_mulx = '0; exp_muly = '0; exp_mulz = '0; exp_mulb = '0;
    endtask

    // Expected outputs for the current cycle (called on the falling edge).
    task automatic predict();
        exp_rspv  = (pend_id.size() > 0) && (pend_t[0] <= cyc);
        exp_id    = exp_rspv ? 2'(pend_id[0]) : 2'd0;
        exp_prod  = exp_rspv ? pend_p[0] : 2'd0;
        exp_issue = 1'b0;
        exp_g     = 0;
        if (pend_id.size() < RSP_DEPTH && rnd_valid)
            for (int i = 0; i < 4; i++)
                if (!exp_issue && req_valid[(ptr + i) % 4]) begin
                    exp_issue = 1'b1;
                    exp_g     = (ptr + i) % 4;
                end
        exp_gnt = exp_issue ? (4'b0001 << exp_g) : 4'b0000;
    endtask

    // Apply this cycle's pop/issue to the model and move past the next edge.
    task automatic advance();
        logic [3:0] xs, ys;
        if (exp_rspv && rsp_ready) begin
            void'(pend_id.pop_front()); void'(pend_p.pop_front()); void'(pend_t.pop_front());
        end
        if (exp_issue) begin
            xs = req_x[exp_g*4 +: 4];
            ys = req_y[exp_g*4 +: 4];
            pend_id.push_back(exp_g);
            pend_p.push_back(gfmul(unm(xs), unm(ys)));
            pend_t.push_back(cyc + 3);
            ptr = (exp_g + 1) % 4;
            exp_mulx = xs; exp_muly = ys; exp_mulz = rnd_z; exp_mulb = rnd_b;
        end else begin
`ifdef DOM_SCHED_IDLE_ZERO_EN
            exp_mulx = '0; exp_muly = '0; exp_mulz = '0; exp_mulb = '0;
`endif
        end
        cyc++;
        @(posedge ClkxCI);
        #1;
    endtask

    task automatic rand_ops();
        req_x = 16'($urandom);
        req_y = 16'($urandom);
        rnd_z = 2'($urandom);
        rnd_b = 4'($urandom);
    endtask

    task automatic test_reset();
        req_valid = 4'hF; rnd_valid = 1'b1; rsp_ready = 1'b1; rand_ops();
        #12;
        asserts++;
        if ({ReqReadyxSO, RndReadyxSO, RspValidxSO} !== 6'b0) begin
            fails++; $display("FAIL reset_hs got=%b exp=0", {ReqReadyxSO, RndReadyxSO, RspValidxSO});
        end
        asserts++;
        if ({MulXxDO, MulYxDO, MulZxDO, MulBxDO, RspIdxDO, RspQxDO} !== 20'b0) begin
            fails++; $display("FAIL reset_data got=%h exp=0", {MulXxDO, MulYxDO, MulZxDO, MulBxDO, RspIdxDO, RspQxDO});
        end
        req_valid = 4'h0;
        @(posedge ClkxCI); #1;
        RstxBI = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        req_valid = 4'b0100; rnd_valid = 1'b1; rsp_ready = 1'b1;
        req_x[11:8] = 4'h6; req_y[11:8] = 4'h9;
        for (int i = 0; i < 6; i++) begin
            @(negedge ClkxCI);
            predict();
            asserts++;
            if (ReqReadyxSO !== ((i == 0) ? 4'b0100 : 4'b0000)) begin
                fails++; $display("FAIL single_grant i=%0d got=%b exp=%b", i, ReqReadyxSO, (i == 0) ? 4'b0100 : 4'b0000);
            end
            asserts++;
            if (RspValidxSO !== (i == 3)) begin
                fails++; $display("FAIL single_rspvalid i=%0d got=%b exp=%b", i, RspValidxSO, i == 3);
            end
            if (i == 3) begin
                asserts++;
                if (RspIdxDO !== 2'd2 || unm(RspQxDO) !== 2'd2) begin
                    fails++; $display("FAIL single_result got id=%0d q=%0d exp id=2 q=2", RspIdxDO, unm(RspQxDO));
                end
            end
            advance();
            req_valid = 4'b0000;
        end
    endtask

    // Checks the model's handshake/response expectations; used by the
    // scenario tasks below each cycle.
    task automatic test_cycle(input string name, input bit chk_mul);
        @(negedge ClkxCI);
        predict();
        asserts++;
        if (ReqReadyxSO !== exp_gnt || RndReadyxSO !== exp_issue) begin
            fails++; $display("FAIL %s_issue cyc=%0d got=%b/%b exp=%b/%b", name, cyc, ReqReadyxSO, RndReadyxSO, exp_gnt, exp_issue);
        end
        asserts++;
        if (RspValidxSO !== exp_rspv) begin
            fails++; $display("FAIL %s_rspvalid cyc=%0d got=%b exp=%b", name, cyc, RspValidxSO, exp_rspv);
        end
        if (exp_rspv) begin
            asserts++;
            if (RspIdxDO !== exp_id || unm(RspQxDO) !== exp_prod) begin
                fails++; $display("FAIL %s_rsp cyc=%0d got id=%0d q=%0d exp id=%0d q=%0d", name, cyc, RspIdxDO, unm(RspQxDO), exp_id, exp_prod);
            end
        end
        if (chk_mul) begin
            asserts++;
            if ({MulXxDO, MulYxDO, MulZxDO, MulBxDO} !== {exp_mulx, exp_muly, exp_mulz, exp_mulb}) begin
                fails++; $display("FAIL %s_mul cyc=%0d got=%h exp=%h", name, cyc, {MulXxDO, MulYxDO, MulZxDO, MulBxDO}, {exp_mulx, exp_muly, exp_mulz, exp_mulb});
            end
        end
    endtask

    task automatic test_round_robin();
        int start, n;
        logic [3:0] want;
        start = ptr; n = 0;
        req_valid = 4'hF; rnd_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_ops();
            test_cycle("rr", 1'b1);
            if (exp_issue) begin
                want = 4'b0001 << ((start + n) % 4);
                asserts++;
                if (ReqReadyxSO !== want) begin
                    fails++; $display("FAIL rr_order n=%0d got=%b exp=%b", n, ReqReadyxSO, want);
                end
                n++;
            end
            advance();
        end
        asserts++;
        if (n < 6) begin
            fails++; $display("FAIL rr_count got=%0d exp>=6", n);
        end
        req_valid = 4'h0;
        for (int i = 0; i < 5; i++) begin test_cycle("rr_drain", 1'b1); advance(); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        req_valid = 4'hF; rnd_valid = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            test_cycle("bp", 1'b0);
            if (ReqReadyxSO != 4'b0) n++;
            advance();
        end
        asserts++;
        if (n != RSP_DEPTH) begin
            fails++; $display("FAIL bp_issues got=%0d exp=%0d", n, RSP_DEPTH);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rand_ops();
            if (i == 8) req_valid = 4'h0;
            test_cycle("bp_resume", 1'b0);
            advance();
        end
    endtask

    task automatic test_rnd_toggle();
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            rnd_valid = ~i[0];
            test_cycle("rnd", 1'b1);
            if (!rnd_valid) begin
                asserts++;
                if (RndReadyxSO !== 1'b0 || ReqReadyxSO !== 4'b0) begin
                    fails++; $display("FAIL rnd_idle cyc=%0d got=%b/%b exp=0/0", cyc, RndReadyxSO, ReqReadyxSO);
                end
            end
            advance();
        end
        req_valid = 4'h0; rnd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin test_cycle("rnd_drain", 1'b1); advance(); end
    endtask

    task automatic test_idle_mul();
        logic [3:0] xs;
        req_valid = 4'b0010; rnd_valid = 1'b1; rsp_ready = 1'b1; rand_ops();
        xs = req_x[7:4];
        test_cycle("idle_issue", 1'b1);
        advance();
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            test_cycle("idle", 1'b1);
            if (i > 0) begin
                asserts++;
`ifdef DOM_SCHED_IDLE_ZERO_EN
                if (MulXxDO !== 4'h0) begin
                    fails++; $display("FAIL idle_mulx got=%h exp=0", MulXxDO);
                end
`else
                if (MulXxDO !== xs) begin
                    fails++; $display("FAIL idle_mulx got=%h exp=%h", MulXxDO, xs);
                end
`endif
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req_valid = 4'($urandom);
            rnd_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            test_cycle("rand", 1'b1);
            advance();
        end
        req_valid = 4'h0; rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin test_cycle("rand_drain", 1'b1); advance(); end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'hF; rnd_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_ops(); test_cycle("rmid_pre", 1'b1); advance(); end
        #2;
        RstxBI = 1'b0;
        #1;
        asserts++;
        if ({ReqReadyxSO, RndReadyxSO, RspValidxSO, MulXxDO, MulYxDO, MulZxDO, MulBxDO, RspIdxDO, RspQxDO} !== 26'b0) begin
            fails++; $display("FAIL rmid_outputs got=%h exp=0", {ReqReadyxSO, RndReadyxSO, RspValidxSO, MulXxDO, MulYxDO, MulZxDO, MulBxDO, RspIdxDO, RspQxDO});
        end
        model_reset();
        @(posedge ClkxCI); @(posedge ClkxCI); #1;
        RstxBI = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rand_ops();
            test_cycle("rmid_post", 1'b1);
            if (i == 0) begin
                asserts++;
                if (ReqReadyxSO !== 4'b0001) begin
                    fails++; $display("FAIL rmid_first_grant got=%b exp=0001", ReqReadyxSO);
                end
            end
            advance();
            req_valid = 4'h0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_rnd_toggle();
        test_idle_mul();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
